// File: rtl/if_id_queue.sv
// ---------------------------------------------------------------------------
// if_id_queue
// Fetch-to-decode instruction queue and pipeline register. Each fetched
// bundle {pc, inst, pc_4, is_branch, t_nt, hit} is pushed into a small FIFO.
// The oldest bundle is presented to decode in first-word-fall-through form.
//
// Ports
//   clk           rising-edge clock
//   rst           asynchronous active-low reset
//   if_valid      fetch presents a bundle this cycle
//   if_*          fetched bundle fields (sampled only on a push)
//   fetch_ready   queue can accept a push; fetch ANDs this into PCWrite
//   id_ready      decode consumes the head bundle (low = hazard stall)
//   flush         mispredict: discard every queued bundle
//   id_valid      head bundle valid
//   id_*          head bundle fields; a NOP bubble when id_valid=0
//   count         current occupancy, 0..DEPTH
// ---------------------------------------------------------------------------
module if_id_queue #(
    parameter int          DEPTH    = 4,
    parameter int          PTR_W    = 2,
    parameter logic [31:0] NOP_INST = 32'h00000013
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             if_valid,
    input  logic [31:0]      if_pc,
    input  logic [31:0]      if_inst,
    input  logic [31:0]      if_pc_4,
    input  logic             if_is_branch,
    input  logic             if_t_nt,
    input  logic             if_hit,
    output logic             fetch_ready,
    input  logic             id_ready,
    input  logic             flush,
    output logic             id_valid,
    output logic [31:0]      id_pc,
    output logic [31:0]      id_inst,
    output logic [31:0]      id_pc_4,
    output logic             id_is_branch,
    output logic             id_t_nt,
    output logic             id_hit,
    output logic [PTR_W:0]   count
);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] pc_4;
        logic        is_branch;
        logic        t_nt;
        logic        hit;
    } bundle_t;

    localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);

    bundle_t          mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W:0]   count_r;

    logic             valid_s;
    logic             pop_s;
    logic             push_s;
    logic             fetch_ready_s;
    bundle_t          head_s;

    // Handshake decode. fetch_ready deliberately depends only on the
    // occupancy and id_ready so there is no loop back through if_valid.
    always_comb begin
        valid_s       = (count_r != {(PTR_W+1){1'b0}});
        pop_s         = id_ready & valid_s;
        fetch_ready_s = (count_r < DEPTH_C) | pop_s;
        push_s        = if_valid & fetch_ready_s;
    end

    // Bundle storage; contents need no reset because reads are qualified
    // by the occupancy. A flushed push is dropped here as well.
    always_ff @(posedge clk) begin
        if (push_s && !flush) begin
            mem_r[wr_ptr_r] <= '{pc: if_pc, inst: if_inst, pc_4: if_pc_4,
                                 is_branch: if_is_branch, t_nt: if_t_nt,
                                 hit: if_hit};
        end
    end

    // Pointers and occupancy. Full/empty is told apart by count only, so the
    // pointers simply wrap modulo DEPTH. Flush overrides push and pop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {(PTR_W+1){1'b0}};
        end else if (flush) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {(PTR_W+1){1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + (PTR_W+1)'(1);
                2'b01:   count_r <= count_r - (PTR_W+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Head presentation: registered rd_ptr selects the entry; an empty queue
    // shows a NOP bubble with every other field cleared.
    always_comb begin
        head_s       = mem_r[rd_ptr_r];
        id_valid     = valid_s;
        id_pc        = 32'h0000_0000;
        id_inst      = NOP_INST;
        id_pc_4      = 32'h0000_0000;
        id_is_branch = 1'b0;
        id_t_nt      = 1'b0;
        id_hit       = 1'b0;
        if (valid_s) begin
            id_pc        = head_s.pc;
            id_inst      = head_s.inst;
            id_pc_4      = head_s.pc_4;
            id_is_branch = head_s.is_branch;
            id_t_nt      = head_s.t_nt;
            id_hit       = head_s.hit;
        end else begin
            id_pc        = 32'h0000_0000;
        end
    end

    assign fetch_ready = fetch_ready_s;
    assign count       = count_r;

endmodule

// File: doc/if_id_queue.md
Name: if_id_queue

Overview:
- Instruction fetch queue and pipeline register between the fetch stage and the decode stage.
- Captures each fetched bundle {pc, inst, PC_4, is_branch, T_NT, hit} into a small FIFO.
- Presents the oldest bundle to decode in first-word-fall-through (FWFT) form.
- Back-pressures fetch through a ready signal that gates PCWrite, and discards all queued bundles on a branch mispredict flush.

Parameters:
- DEPTH, 4, number of queued bundles; power of two, 2..16.
- PTR_W, 2, pointer width; equals log2(DEPTH).
- NOP_INST, 32'h00000013, instruction word driven to decode when no valid bundle is present.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset; asynchronous, active-low.
- if_valid  in  1  fetch stage presents a bundle this cycle.
- if_pc  in  32  fetched pc.
- if_inst  in  32  fetched instruction.
- if_pc_4  in  32  pc + 4.
- if_is_branch  in  1  predictor branch flag.
- if_t_nt  in  1  BHT taken prediction.
- if_hit  in  1  BTB hit.
- fetch_ready  out  1  queue can accept a push this cycle; fetch ANDs it into PCWrite.
- id_ready  in  1  decode consumes the head bundle this cycle; low means hazard stall.
- flush  in  1  mispredict (miss_predict / PCSrc); discard all entries.
- id_valid  out  1  head bundle valid.
- id_pc  out  32  head pc.
- id_inst  out  32  head instruction, or NOP_INST when id_valid=0.
- id_pc_4  out  32  head pc + 4.
- id_is_branch  out  1  head branch flag.
- id_t_nt  out  1  head taken prediction.
- id_hit  out  1  head BTB hit.
- count  out  PTR_W+1  current occupancy, 0..DEPTH.

Behaviour:
- Reset (rst=0, asynchronous):
  - wr_ptr=0, rd_ptr=0, count=0.
  - id_valid=0, id_inst=NOP_INST, all other id_* outputs = 0.
  - fetch_ready=1.
  - Storage contents are don't-care.
- Signal definitions:
  - pop = id_ready & id_valid.
  - push = if_valid & fetch_ready.
  - fetch_ready = (count < DEPTH) | pop. This is combinational from count and id_ready; there is no combinational path from if_valid.
- Push: writes the bundle at wr_ptr and increments wr_ptr modulo DEPTH on the clock edge.
- Pop: increments rd_ptr modulo DEPTH.
- Occupancy update: count += push - pop. Simultaneous push and pop leaves count unchanged, including when full and when count=1.
- Pointer wrap: both pointers wrap naturally at DEPTH. Full and empty are distinguished by count, not by pointer equality.
- FWFT latency:
  - A bundle pushed at edge N drives the id_* outputs from edge N onward (visible in cycle N+1) if the queue was empty.
  - id_* outputs come from the head storage entry, selected by registered rd_ptr, qualified by id_valid = (count != 0).
- When id_valid=0: id_inst=NOP_INST and all other id_* fields = 0, so decode sees a bubble.
- Stall: id_ready=0 holds the head bundle stable on the id_* outputs. Pushes continue until count=DEPTH, after which fetch_ready=0.
- Flush:
  - At the edge, count=0, wr_ptr=0, rd_ptr=0.
  - Flush has priority over push and pop in the same cycle. The pushed bundle is dropped and no pop is counted.
  - Next cycle: id_valid=0, fetch_ready=1.
- Flush while empty: no effect besides resetting the pointers.
- Reset mid-operation: immediate return to the reset state, with no dependence on clk.
- if_valid while fetch_ready=0: ignored, no write.
- if_* inputs are sampled only when push=1.

Test Plan:
- Reset, then push pc=0x00, 0x04, 0x08 with id_ready=1 continuously -> id_pc shows 0x00, 0x04, 0x08 on consecutive cycles, each one cycle after its push; count never exceeds 1.
- id_ready=0, push 5 bundles (pc 0x10..0x20) with DEPTH=4 -> count=4, fetch_ready=0 after the 4th push, 5th bundle not written, id_pc holds 0x10.
- Full queue, id_ready=1 and if_valid=1 same cycle with pc=0x40 -> count stays 4, id_pc advances 0x10 to 0x14, 0x40 lands at the tail; draining yields 0x14, 0x18, 0x1C, 0x40.
- Three entries queued, flush=1 together with push of pc=0x80 -> next cycle count=0, id_valid=0, id_inst=32'h00000013; next push of 0x84 appears as head (0x80 never appears).
- Push/pop 10 bundles through DEPTH=4 with alternating stalls, including is_branch=1, T_NT=1, hit=1 on pc=0x24 -> output order preserved across pointer wrap, and the branch flags arrive with 0x24 only.
- Assert rst=0 asynchronously mid-cycle with count=3 -> id_valid=0 and count=0 immediately, before the next clk edge.
